// File: rtl/jtag_ir_param.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_ir_param
//  Description : Parameterised JTAG instruction register. It holds a capture/
//                shift register clocked on the rising edge of tck and a
//                one-hot instruction decode latched on the falling edge of tck
//                during Update-IR. Unmatched opcodes decode to BYPASS and
//                raise a sticky unknown_op flag.
//                Optional feature macro: IR_PARITY_EN. When it is defined, an
//                odd-parity bit is added above the opcode. It is shifted in
//                last and checked on update.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_ir_param #(
    parameter int IR_WIDTH   = 5,
    parameter int INST_COUNT = 9,
    // Entry k occupies bits [k*IR_WIDTH +: IR_WIDTH]. Entry 0 is BYPASS and
    // entry 1 is IDCODE. The last item of the concatenation is entry 0.
    parameter logic [INST_COUNT*IR_WIDTH-1:0] OPCODE_TABLE = {
        5'b01010,   // 8 RESUME
        5'b01001,   // 7 STEP
        5'b01000,   // 6 HALT
        5'b00100,   // 5 CLAMP
        5'b00011,   // 4 INTEST
        5'b00000,   // 3 EXTEST
        5'b00010,   // 2 SAMPLE_PRELOAD
        5'b00001,   // 1 IDCODE
        5'b11111    // 0 BYPASS
    }
) (
    input  logic                  tck,
    input  logic                  tl_reset,
    input  logic                  tdi,
    input  logic                  capture_ir,
    input  logic                  shift_ir,
    input  logic                  update_ir,
    input  logic [IR_WIDTH-3:0]   status_in,
    output logic                  tdo,
    output logic                  tdo_en,
    output logic [INST_COUNT-1:0] instructions,
    output logic                  unknown_op,
    output logic                  parity_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
`ifdef IR_PARITY_EN
    localparam int c_SR_W = IR_WIDTH + 1;
`else
    localparam int c_SR_W = IR_WIDTH;
`endif

    // The shift register resets to ...0001. This is the IDCODE opcode in the
    // default table, so an update right after reset reproduces the reset
    // instruction.
    localparam logic [c_SR_W-1:0]     c_SR_RST      = c_SR_W'(1);
    localparam logic [INST_COUNT-1:0] c_INST_BYPASS = INST_COUNT'(1);
    localparam logic [INST_COUNT-1:0] c_INST_IDCODE = INST_COUNT'(2);

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [c_SR_W-1:0]     r_sr;
    logic                  r_tdo;
    logic                  r_tdo_en;
    logic [INST_COUNT-1:0] r_instructions;
    logic                  r_unknown_op;

    logic [IR_WIDTH-1:0]   w_cap_ir;      // capture pattern for the opcode field
    logic [c_SR_W-1:0]     w_cap;         // full capture pattern
    logic [IR_WIDTH-1:0]   w_opcode;      // opcode field of the shift register
    logic [INST_COUNT-1:0] w_dec;         // one-hot decode of w_opcode
    logic                  w_miss;        // no table entry matched w_opcode

    // ------------------------------------------------------------------------
    // Capture pattern
    // ------------------------------------------------------------------------
    // The two LSBs always capture 2'b01, as IEEE 1149.1 requires. The status
    // bits fill the rest of the field. A 2-bit register has no room for them.
    generate
        if (IR_WIDTH > 2) begin : g_cap_status
            assign w_cap_ir = {status_in, 2'b01};
        end else begin : g_cap_nostatus
            assign w_cap_ir = 2'b01;
        end
    endgenerate

`ifdef IR_PARITY_EN
    logic r_parity_err;
    logic w_parity_ok;

    // Capturing the sticky error into the parity position lets the host see
    // whether the previous instruction was rejected.
    assign w_cap       = {r_parity_err, w_cap_ir};

    // Odd parity across the opcode and the parity bit is the valid case.
    assign w_parity_ok = ^r_sr;
    assign parity_err  = r_parity_err;
`else
    assign w_cap       = w_cap_ir;
    assign parity_err  = 1'b0;
`endif

    assign w_opcode = r_sr[IR_WIDTH-1:0];

    // ------------------------------------------------------------------------
    // Shift register
    // ------------------------------------------------------------------------
    // Rising edge of tck: capture has priority over shift, otherwise hold.
    // A right shift puts tdi into the MSB, so the LSB goes out first.
    always_ff @(posedge tck or negedge tl_reset) begin
        if (!tl_reset) begin
            r_sr <= c_SR_RST;
        end else if (capture_ir) begin
            r_sr <= w_cap;
        end else if (shift_ir) begin
            r_sr <= {tdi, r_sr[c_SR_W-1:1]};
        end
    end

    // ------------------------------------------------------------------------
    // Opcode decoder
    // ------------------------------------------------------------------------
    // Scan the table in ascending order, so the lowest matching index wins
    // when the table contains duplicates. A miss falls back to BYPASS. This
    // keeps w_dec one-hot for any register contents.
    always_comb begin
        w_dec  = '0;
        w_miss = 1'b1;
        for (int k = 0; k < INST_COUNT; k++) begin
            if (w_miss && (w_opcode == OPCODE_TABLE[k*IR_WIDTH +: IR_WIDTH])) begin
                w_dec[k] = 1'b1;
                w_miss   = 1'b0;
            end
        end
        if (w_miss) begin
            w_dec[0] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Serial output
    // ------------------------------------------------------------------------
    // Falling edge of tck: present the register LSB while shifting. tdo is
    // forced low outside Shift-IR, so an idle port reads 0 rather than a
    // stale register bit.
    always_ff @(negedge tck or negedge tl_reset) begin
        if (!tl_reset) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else begin
            r_tdo    <= shift_ir & r_sr[0];
            r_tdo_en <= shift_ir;
        end
    end

    // ------------------------------------------------------------------------
    // Instruction update
    // ------------------------------------------------------------------------
    // Falling edge of tck during Update-IR: latch the decode. The control
    // signals of a TAP state change just after a rising edge. The decode here
    // therefore always sees the register as it stood before the rising edge
    // that acts on a capture or shift asserted alongside update_ir.
    // The instructions change only here and on reset. A parity failure
    // forces BYPASS and leaves unknown_op as it was.
    always_ff @(negedge tck or negedge tl_reset) begin
        if (!tl_reset) begin
            r_instructions <= c_INST_IDCODE;
            r_unknown_op   <= 1'b0;
`ifdef IR_PARITY_EN
            r_parity_err   <= 1'b0;
`endif
        end else if (update_ir) begin
`ifdef IR_PARITY_EN
            if (!w_parity_ok) begin
                r_instructions <= c_INST_BYPASS;
                r_parity_err   <= 1'b1;
            end else begin
                r_instructions <= w_dec;
                r_unknown_op   <= w_miss;
                r_parity_err   <= 1'b0;
            end
`else
            r_instructions <= w_dec;
            r_unknown_op   <= w_miss;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tdo          = r_tdo;
    assign tdo_en       = r_tdo_en;
    assign instructions = r_instructions;
    assign unknown_op   = r_unknown_op;

endmodule
`default_nettype wire

// File: tb/tb_jtag_ir_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_ir_param
//  Description : Directed self-checking bench for jtag_ir_param (default
//                parameters). Inputs change 1 time unit after a rising edge,
//                as a TAP controller drives them. Outputs are sampled 1 time
//                unit after a falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_ir_param;

    logic       tck;
    logic       tl_reset;
    logic       tdi;
    logic       capture_ir;
    logic       shift_ir;
    logic       update_ir;
    logic [2:0] status_in;
    logic       tdo;
    logic       tdo_en;
    logic [8:0] instructions;
    logic       unknown_op;
    logic       parity_err;

    int n_assert = 0;
    int n_fail   = 0;

    jtag_ir_param u_dut (
        .tck          (tck),
        .tl_reset     (tl_reset),
        .tdi          (tdi),
        .capture_ir   (capture_ir),
        .shift_ir     (shift_ir),
        .update_ir    (update_ir),
        .status_in    (status_in),
        .tdo          (tdo),
        .tdo_en       (tdo_en),
        .instructions (instructions),
        .unknown_op   (unknown_op),
        .parity_err   (parity_err)
    );

    // Free-running clock with a 10-unit period
    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end of the test");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One TCK cycle: drive after the rising edge, return just after the falling edge
    task automatic step(input logic cap, input logic sh, input logic up, input logic d);
        @(posedge tck);
        #1;
        capture_ir = cap;
        shift_ir   = sh;
        update_ir  = up;
        tdi        = d;
        @(negedge tck);
        #1;
    endtask

    // Shift n bits of v, LSB first (last bit is clocked on the following edge)
    task automatic shift_val(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b0, v[i]);
        end
    endtask

    initial begin
        logic [7:0] v_tseq;
        tl_reset   = 1'b0;
        tdi        = 1'b0;
        capture_ir = 1'b0;
        shift_ir   = 1'b0;
        update_ir  = 1'b0;
        status_in  = 3'b000;

        // Reset values, held before any clocking matters
        #12;
        check("rst_instr",  32'(instructions), 32'h002);
        check("rst_unk",    32'(unknown_op),   32'h0);
        check("rst_tdo",    32'(tdo),          32'h0);
        check("rst_tdo_en", 32'(tdo_en),       32'h0);
        check("rst_perr",   32'(parity_err),   32'h0);

        @(posedge tck);
        #1;
        tl_reset = 1'b1;

`ifndef IR_PARITY_EN
        // Release with no update: IDCODE stays, tdo quiet
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_instr", 32'(instructions), 32'h002);
        check("idle_unk",   32'(unknown_op),   32'h0);
        check("idle_tdo",   32'(tdo),          32'h0);

        // Capture status 101 -> sr=10101. Shift it out while shifting in INTEST 00011
        status_in = 3'b101;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("cap_tdo_en", 32'(tdo_en), 32'h0);
        v_tseq = 8'b0001_0101;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, v_tseq[0] ? (i < 2) : 1'b0);
            check($sformatf("shift_tdo_%0d", i),    32'(tdo),    32'(v_tseq[i]));
            check($sformatf("shift_tdo_en_%0d", i), 32'(tdo_en), 32'h1);
        end
        check("shift_instr_hold", 32'(instructions), 32'h002);

        // Update: fifth shift lands on this rising edge, decode INTEST
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("intest_instr",  32'(instructions), 32'h010);
        check("intest_unk",    32'(unknown_op),   32'h0);
        check("upd_tdo_en",    32'(tdo_en),       32'h0);
        check("upd_tdo",       32'(tdo),          32'h0);

        // Unmatched opcode 10101 -> BYPASS with unknown_op
        shift_val(8'b0001_0101, 5);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("miss_instr", 32'(instructions), 32'h001);
        check("miss_unk",   32'(unknown_op),   32'h1);

        // Valid CLAMP 00100 clears unknown_op
        shift_val(8'b0000_0100, 5);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("clamp_instr", 32'(instructions), 32'h020);
        check("clamp_unk",   32'(unknown_op),   32'h0);

        // Update together with the last shift of HALT 01000: decodes the
        // pre-shift value 10000 (no match), then a plain update gives HALT
        shift_val(8'b0000_1000, 4);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("conflict_instr", 32'(instructions), 32'h001);
        check("conflict_unk",   32'(unknown_op),   32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("halt_instr", 32'(instructions), 32'h040);
        check("halt_unk",   32'(unknown_op),   32'h0);

        // Reset mid-shift: sr would be 00010 (SAMPLE_PRELOAD) if not reset
        shift_val(8'b0000_1000, 3);
        tl_reset = 1'b0;
        #1;
        check("midrst_instr",  32'(instructions), 32'h002);
        check("midrst_unk",    32'(unknown_op),   32'h0);
        check("midrst_tdo_en", 32'(tdo_en),       32'h0);
        shift_ir = 1'b0;
        @(posedge tck);
        #1;
        tl_reset = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("postrst_instr", 32'(instructions), 32'h002);
        check("postrst_unk",   32'(unknown_op),   32'h0);

        // Capture wins over shift: status 010 -> sr=01001 (STEP)
        status_in = 3'b010;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("cap_prio_instr", 32'(instructions), 32'h080);
        check("end_perr",       32'(parity_err),   32'h0);
`else
        // Parity bit 1 on 00010: XOR over all six bits = 0 -> rejected
        shift_val(8'b0010_0010, 6);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("par_bad_instr", 32'(instructions), 32'h001);
        check("par_bad_perr",  32'(parity_err),   32'h1);
        check("par_bad_unk",   32'(unknown_op),   32'h0);

        // Capture shows the error in sr[5]: captured 1_000_01 -> tdo 1,0,0,0,0,1
        status_in = 3'b000;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        v_tseq = 8'b0010_0001;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, (i == 1));
            check($sformatf("par_tdo_%0d", i), 32'(tdo), 32'(v_tseq[i]));
        end

        // Parity bit 0 on 00010: XOR = 1 -> SAMPLE_PRELOAD, error cleared
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("par_ok_instr", 32'(instructions), 32'h004);
        check("par_ok_perr",  32'(parity_err),   32'h0);
        check("par_ok_unk",   32'(unknown_op),   32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
